// File: rtl/mono_rx_readout_arbiter_if.sv
// Bus bundle for the receiver readout arbiter: source FIFO heads and pop
// strobes on one side, the merged first-word-fall-through stream on the other.
interface mono_rx_readout_arbiter_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0]    ENABLE_MASK;
   logic [N_SRC-1:0]    SRC_EMPTY;
   logic [32*N_SRC-1:0] SRC_DATA;
   logic [N_SRC-1:0]    SRC_READ;
   logic                FIFO_READ;
   logic                FIFO_EMPTY;
   logic [31:0]         FIFO_DATA;
   logic [N_SRC-1:0]    GRANT;
   logic [7:0]          FRAME_ERR_CNT;
   logic                BUSY;

   // Arbiter side.
   modport master (
      input  ENABLE_MASK, SRC_EMPTY, SRC_DATA, FIFO_READ,
      output SRC_READ, FIFO_EMPTY, FIFO_DATA, GRANT, FRAME_ERR_CNT, BUSY
   );

   // Environment side: source FIFOs and the downstream reader.
   modport slave (
      output ENABLE_MASK, SRC_EMPTY, SRC_DATA, FIFO_READ,
      input  SRC_READ, FIFO_EMPTY, FIFO_DATA, GRANT, FRAME_ERR_CNT, BUSY
   );
endinterface

// File: rtl/mono_rx_readout_arbiter.sv
// Round-robin, frame-atomic merge of N_SRC receiver word FIFOs into a single
// first-word-fall-through output register. A grant is held for a full frame;
// a frame that stalls too long is dropped and counted.
module mono_rx_readout_arbiter #(
   parameter int N_SRC           = 4,
   parameter int WORDS_PER_FRAME = 3,
   parameter int FRAME_TIMEOUT   = 255
) (
   input  logic                     BUS_CLK,
   input  logic                     BUS_RST_N,
   mono_rx_readout_arbiter_if.master bus
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int WC_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME + 1) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  g_idx, g_idx_nxt;
   logic [IDX_W-1:0]  last_grant, last_grant_nxt;
   logic [WC_W-1:0]   word_cnt, word_cnt_nxt;
   logic [7:0]        stall_cnt, stall_cnt_nxt;
   logic [7:0]        err_cnt;
   logic              err_inc;
   logic              fifo_empty;
   logic [31:0]       fifo_data;
   logic              can_load;
   logic              pop;
   logic [N_SRC-1:0]  req;
   logic [N_SRC-1:0]  grant;
   logic [N_SRC-1:0]  src_read;
   logic [31:0]       head;
   logic              found;
   logic [IDX_W-1:0]  winner;
   logic [IDX_W-1:0]  cand;

   assign can_load = fifo_empty | bus.FIFO_READ;
   assign req      = bus.ENABLE_MASK & ~bus.SRC_EMPTY;

   // One-hot grant decoded from the registered index; zero outside LOCK.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      if (state == LOCK) grant[g_idx] = 1'b1;
   end

   // The pop strobe follows the registered grant; only one source can be granted.
   assign src_read = can_load ? (grant & ~bus.SRC_EMPTY) : '0;
   assign pop      = |src_read;
   assign head     = bus.SRC_DATA[32*int'(g_idx) +: 32];

   // Rotating priority search starting just after the last served source.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = IDX_W'((int'(last_grant) + k) % N_SRC);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Next-state logic: grant in IDLE, count words and stall cycles in LOCK.
   always_comb begin
      state_nxt      = state;
      g_idx_nxt      = g_idx;
      last_grant_nxt = last_grant;
      word_cnt_nxt   = word_cnt;
      stall_cnt_nxt  = stall_cnt;
      err_inc        = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               g_idx_nxt     = winner;
               word_cnt_nxt  = '0;
               stall_cnt_nxt = '0;
               state_nxt     = LOCK;
            end
         end
         LOCK: begin
            if (pop) begin
               stall_cnt_nxt = '0;
               if (word_cnt == WC_W'(WORDS_PER_FRAME - 1)) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = g_idx;
                  word_cnt_nxt   = '0;
               end else begin
                  word_cnt_nxt = word_cnt + 1'b1;
               end
            end else if (({1'b0, stall_cnt} + 9'd1) == 9'(FRAME_TIMEOUT)) begin
               state_nxt      = IDLE;
               last_grant_nxt = g_idx;
               stall_cnt_nxt  = '0;
               err_inc        = 1'b1;
            end else begin
               stall_cnt_nxt = stall_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any partial frame without counting it.
   always_ff @(posedge BUS_CLK) begin
      // NOTE: reset is sampled on the clock edge only, so it is written as the first branch of a plain posedge block.
      if (!BUS_RST_N) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state      <= IDLE;
         g_idx      <= '0;
         last_grant <= IDX_W'(N_SRC - 1);
         word_cnt   <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         g_idx      <= g_idx_nxt;
         last_grant <= last_grant_nxt;
         word_cnt   <= word_cnt_nxt;
         stall_cnt  <= stall_cnt_nxt;
      end
   end

   // Saturating count of frames released by timeout.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         err_cnt <= '0;
      end else if (err_inc && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

   // Output register: load on a pop, go empty only when consumed without a reload.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else if (pop) begin
         fifo_empty <= 1'b0;
         fifo_data  <= head;
      end else if (bus.FIFO_READ) begin
         fifo_empty <= 1'b1;
      end
   end

   assign bus.SRC_READ      = src_read;
   assign bus.FIFO_EMPTY    = fifo_empty;
   assign bus.FIFO_DATA     = fifo_data;
   assign bus.GRANT         = grant;
   assign bus.FRAME_ERR_CNT = err_cnt;
   assign bus.BUSY          = (state == LOCK);

endmodule
